// File: rtl/axi_up_pkg.sv
// rtl/axi_up_pkg.sv - shared FSM state and descriptor types for the descriptor queue
package axi_up_pkg;

    localparam int DESC_ADDR_MAX = 64;
    localparam int DESC_SIZE_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    // Fields are sized for the widest supported build; narrower builds zero-extend.
    typedef struct packed {
        logic [DESC_ADDR_MAX-1:0] src;
        logic [DESC_ADDR_MAX-1:0] dst;
        logic [DESC_SIZE_MAX-1:0] size;
    } desc_t;

endpackage

// File: rtl/axi_up_desc_fifo.sv
// rtl/axi_up_desc_fifo.sv - circular descriptor store with flush that can retain the head
module axi_up_desc_fifo
    import axi_up_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  desc_t            push_desc,
    input  logic             pop,
    input  logic             flush,
    input  logic             keep_head,
    output desc_t            head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    desc_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    assign rd_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a flush rebuilds wr_ptr behind the surviving head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (flush) begin
                wr_ptr <= rd_next + PTR_W'(keep_head);
                count  <= CNT_W'(keep_head);
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Descriptor storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_desc;
        end
    end

endmodule

// File: rtl/axi_up_desc_queue.sv
// rtl/axi_up_desc_queue.sv - descriptor queue feeding a copy engine; AXI_UP_ZERO_SIZE_DROP_EN retires size-0 entries without a trigger
module axi_up_desc_queue
    import axi_up_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int REG_SIZE_WIDTH = 15,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         push_i,
    input  logic [AXI_ADDR_WIDTH-1:0]    push_src_i,
    input  logic [AXI_ADDR_WIDTH-1:0]    push_dst_i,
    input  logic [REG_SIZE_WIDTH-1:0]    push_size_i,
    input  logic                         flush_i,
    input  logic                         clr_ovf_i,
    output logic [AXI_ADDR_WIDTH-1:0]    src_addr_o,
    output logic [AXI_ADDR_WIDTH-1:0]    dst_addr_o,
    output logic [REG_SIZE_WIDTH-1:0]    size_o,
    output logic                         cmd_trigger_pulse_o,
    input  logic                         status_busy_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         overflow_o,
    output logic [7:0]                   done_cnt_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t state;
    state_t state_next;
    desc_t  push_desc;
    desc_t  head;
    logic   push_ok;
    logic   push_drop;
    logic   pop;
    logic   load;
    logic   trigger;
    logic   keep_head;
    logic   unused_head;

    // A push coinciding with a flush is discarded silently; otherwise a full queue drops it.
    assign push_ok   = push_i && !full_o && !flush_i;
    assign push_drop = push_i &&  full_o && !flush_i;
    assign keep_head = (state != ST_IDLE) && !pop;

    assign push_desc = '{src:  DESC_ADDR_MAX'(push_src_i),
                         dst:  DESC_ADDR_MAX'(push_dst_i),
                         size: DESC_SIZE_MAX'(push_size_i)};

    assign full_o              = (count_o == CNT_W'(DEPTH));
    assign empty_o             = (count_o == '0);
    assign cmd_trigger_pulse_o = trigger;
    assign unused_head         = ^head;

    axi_up_desc_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (push_ok),
        .push_desc (push_desc),
        .pop       (pop),
        .flush     (flush_i),
        .keep_head (keep_head),
        .head      (head),
        .count     (count_o)
    );

    // Sequencer state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, head load/pop and the one-cycle trigger; starting is held off during a flush
    // so the head being loaded cannot be flushed away underneath the engine.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        trigger    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty_o && !flush_i) begin
`ifdef AXI_UP_ZERO_SIZE_DROP_EN
                    if (head.size == '0) begin
                        pop = 1'b1;
                    end else if (!status_busy_i) begin
                        load       = 1'b1;
                        state_next = ST_ISSUE;
                    end
`else
                    if (!status_busy_i) begin
                        load       = 1'b1;
                        state_next = ST_ISSUE;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                trigger    = 1'b1;
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (status_busy_i) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!status_busy_i) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Engine-facing descriptor, completion counter and sticky overflow (set beats clear).
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            src_addr_o <= '0;
            dst_addr_o <= '0;
            size_o     <= '0;
            done_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (load) begin
                src_addr_o <= head.src[AXI_ADDR_WIDTH-1:0];
                dst_addr_o <= head.dst[AXI_ADDR_WIDTH-1:0];
                size_o     <= head.size[REG_SIZE_WIDTH-1:0];
            end
            if (pop) begin
                done_cnt_o <= done_cnt_o + 8'd1;
            end
            if (push_drop) begin
                overflow_o <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_up_desc_queue.sv
// tb/tb_axi_up_desc_queue.sv - randomized scoreboard bench for axi_up_desc_queue (honours AXI_UP_ZERO_SIZE_DROP_EN)
module tb_axi_up_desc_queue;

    localparam int DEPTH = 4;
    localparam int SW    = 15;
    localparam int AW    = 32;
`ifdef AXI_UP_ZERO_SIZE_DROP_EN
    localparam int ZERO_TRIGS = 0;
`else
    localparam int ZERO_TRIGS = 1;
`endif

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          push_i = 1'b0;
    logic [AW-1:0] push_src_i = '0;
    logic [AW-1:0] push_dst_i = '0;
    logic [SW-1:0] push_size_i = '0;
    logic          flush_i = 1'b0;
    logic          clr_ovf_i = 1'b0;
    logic [AW-1:0] src_addr_o;
    logic [AW-1:0] dst_addr_o;
    logic [SW-1:0] size_o;
    logic          cmd_trigger_pulse_o;
    logic          status_busy_i;
    logic [2:0]    count_o;
    logic          full_o;
    logic          empty_o;
    logic          overflow_o;
    logic [7:0]    done_cnt_o;

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [SW-1:0] size;
    } d_t;

    // Reference model: queued descriptors (front is the in-flight one when inflight is set).
    d_t           mq[$];
    bit           inflight;
    bit           seen_busy;
    bit           ovf;
    byte unsigned done;
    bit           pop_now;
    bit           pre_full;

    int errors;
    int checks;
    int trig_cnt;

    // Copy-engine model.
    logic eng_busy = 1'b0;
    logic hold_busy = 1'b0;
    bit   eng_fixed;
    int   eng_st;
    int   eng_wait;
    int   eng_len;

    assign status_busy_i = eng_busy | hold_busy;

    always #5 ACLK = ~ACLK;

    axi_up_desc_queue #(
        .DEPTH          (DEPTH),
        .REG_SIZE_WIDTH (SW),
        .AXI_ADDR_WIDTH (AW)
    ) dut (
        .ACLK                (ACLK),
        .ARESET              (ARESET),
        .push_i              (push_i),
        .push_src_i          (push_src_i),
        .push_dst_i          (push_dst_i),
        .push_size_i         (push_size_i),
        .flush_i             (flush_i),
        .clr_ovf_i           (clr_ovf_i),
        .src_addr_o          (src_addr_o),
        .dst_addr_o          (dst_addr_o),
        .size_o              (size_o),
        .cmd_trigger_pulse_o (cmd_trigger_pulse_o),
        .status_busy_i       (status_busy_i),
        .count_o             (count_o),
        .full_o              (full_o),
        .empty_o             (empty_o),
        .overflow_o          (overflow_o),
        .done_cnt_o          (done_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge from the inputs and the pre-edge trigger/busy.
    always @(posedge ACLK) begin
        if (ARESET) begin
            mq.delete();
            inflight  = 0;
            seen_busy = 0;
            ovf       = 0;
            done      = 0;
        end else begin
            pre_full = (mq.size() == DEPTH);
            pop_now  = 0;
            if (cmd_trigger_pulse_o) inflight = 1;
            if (inflight && seen_busy && !status_busy_i) begin
                pop_now   = 1;
                inflight  = 0;
                seen_busy = 0;
            end else if (inflight && status_busy_i) begin
                seen_busy = 1;
            end
`ifdef AXI_UP_ZERO_SIZE_DROP_EN
            else if (!inflight && mq.size() > 0 && mq[0].size == 0 && !flush_i) begin
                pop_now = 1;
            end
`endif
            if (pop_now) begin
                void'(mq.pop_front());
                done++;
            end
            if (flush_i) begin
                while (mq.size() > (inflight ? 1 : 0)) void'(mq.pop_back());
            end else if (push_i) begin
                if (pre_full) ovf = 1;
                else mq.push_back('{src: push_src_i, dst: push_dst_i, size: push_size_i});
            end
            if (clr_ovf_i && !(push_i && pre_full && !flush_i)) ovf = 0;
        end
    end

    // Monitor: status against the model every cycle; each trigger against the queue head.
    always @(posedge ACLK) begin
        #1;
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("full", 64'(full_o), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty_o), 64'(mq.size() == 0));
        chk("overflow", 64'(overflow_o), 64'(ovf));
        chk("done_cnt", 64'(done_cnt_o), 64'(done));
        if (cmd_trigger_pulse_o) begin
            chk("trigger_while_busy", 64'(status_busy_i), 64'(0));
            if (inflight || mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_trigger: inflight=%0d queued=%0d at %0t", inflight, mq.size(), $time);
            end else begin
                chk("trig_src", 64'(src_addr_o), 64'(mq[0].src));
                chk("trig_dst", 64'(dst_addr_o), 64'(mq[0].dst));
                chk("trig_size", 64'(size_o), 64'(mq[0].size));
                trig_cnt++;
            end
        end else if (inflight && mq.size() > 0) begin
            chk("hold_src", 64'(src_addr_o), 64'(mq[0].src));
            chk("hold_dst", 64'(dst_addr_o), 64'(mq[0].dst));
            chk("hold_size", 64'(size_o), 64'(mq[0].size));
        end
    end

    // Engine: after a trigger wait a little, then stay busy for a while.
    always @(negedge ACLK) begin
        if (ARESET) begin
            eng_st   = 0;
            eng_busy = 1'b0;
        end else begin
            case (eng_st)
                0: if (cmd_trigger_pulse_o) begin
                    eng_wait = eng_fixed ? 1 : int'($urandom_range(1, 3));
                    eng_len  = eng_fixed ? 10 : int'($urandom_range(1, 6));
                    eng_st   = 1;
                end
                1: begin
                    eng_wait--;
                    if (eng_wait == 0) begin
                        eng_busy = 1'b1;
                        eng_st   = 2;
                    end
                end
                default: begin
                    eng_len--;
                    if (eng_len == 0) begin
                        eng_busy = 1'b0;
                        eng_st   = 0;
                    end
                end
            endcase
        end
    end

    task automatic push_desc(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [SW-1:0] z);
        push_i      = 1'b1;
        push_src_i  = s;
        push_dst_i  = d;
        push_size_i = z;
        @(negedge ACLK);
        push_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((mq.size() != 0 || inflight || status_busy_i) && n < 3000) begin
            @(negedge ACLK);
            n++;
        end
        repeat (2) @(negedge ACLK);
        chk({name, "_drain_in_time"}, 64'(n < 3000), 64'(1));
    endtask

    task automatic wait_wait_done(input string name);
        int n = 0;
        while (!seen_busy && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        chk({name, "_reached_wait_done"}, 64'(seen_busy), 64'(1));
    endtask

    initial begin
        int t0;
        int d0;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int t0;
        int d0;
        eng_fixed = 1;
        repeat (2) @(negedge ACLK);
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_empty", 64'(empty_o), 64'(1));
        chk("rst_full", 64'(full_o), 64'(0));
        chk("rst_trigger", 64'(cmd_trigger_pulse_o), 64'(0));
        chk("rst_src", 64'(src_addr_o), 64'(0));
        ARESET = 1'b0;
        @(negedge ACLK);

        // Single descriptor.
        t0 = trig_cnt;
        push_desc(32'h1000, 32'h2000, 15'd64);
        drain("single");
        chk("single_triggers", 64'(trig_cnt - t0), 64'(1));
        chk("single_done", 64'(done_cnt_o), 64'(1));
        chk("single_empty", 64'(empty_o), 64'(1));

        // Fill and overflow with the engine held busy.
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) push_desc(32'h100 * (i + 1), 32'h8000 + i, 15'(i + 1));
        @(negedge ACLK);
        chk("fill_count", 64'(count_o), 64'(4));
        chk("fill_full", 64'(full_o), 64'(1));
        chk("fill_overflow", 64'(overflow_o), 64'(1));
        clr_ovf_i = 1'b1;
        push_desc(32'hdead, 32'hbeef, 15'd7);
        clr_ovf_i = 1'b0;
        @(negedge ACLK);
        chk("set_beats_clear", 64'(overflow_o), 64'(1));
        clr_ovf_i = 1'b1;
        @(negedge ACLK);
        clr_ovf_i = 1'b0;
        @(negedge ACLK);
        chk("ovf_cleared", 64'(overflow_o), 64'(0));
        hold_busy = 1'b0;
        drain("fill");
        chk("fill_done", 64'(done_cnt_o), 64'(5));

        // Back-to-back with a fixed 10-cycle engine.
        t0 = trig_cnt;
        d0 = int'(done_cnt_o);
        for (int i = 0; i < 3; i++) push_desc(32'hA000 + i, 32'hB000 + i, 15'(100 + i));
        drain("b2b");
        chk("b2b_triggers", 64'(trig_cnt - t0), 64'(3));
        chk("b2b_done", 64'(done_cnt_o), 64'(8'(d0 + 3)));

        // Flush while the head is in WAIT_DONE.
        d0 = int'(done_cnt_o);
        for (int i = 0; i < 3; i++) push_desc(32'hC000 + i, 32'hD000 + i, 15'(200 + i));
        wait_wait_done("flush");
        flush_i = 1'b1;
        @(negedge ACLK);
        flush_i = 1'b0;
        chk("flush_count", 64'(count_o), 64'(1));
        drain("flush");
        chk("flush_empty", 64'(empty_o), 64'(1));
        chk("flush_done", 64'(done_cnt_o), 64'(8'(d0 + 1)));

        // Reset in the middle of a transfer.
        push_desc(32'hE000, 32'hF000, 15'd300);
        push_desc(32'hE100, 32'hF100, 15'd301);
        wait_wait_done("reset");
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("midrst_src", 64'(src_addr_o), 64'(0));
        chk("midrst_dst", 64'(dst_addr_o), 64'(0));
        chk("midrst_size", 64'(size_o), 64'(0));
        chk("midrst_count", 64'(count_o), 64'(0));
        chk("midrst_done", 64'(done_cnt_o), 64'(0));
        chk("midrst_empty", 64'(empty_o), 64'(1));
        ARESET = 1'b0;
        t0 = trig_cnt;
        repeat (20) @(negedge ACLK);
        chk("midrst_no_trigger", 64'(trig_cnt - t0), 64'(0));

        // Zero-size descriptor.
        t0 = trig_cnt;
        push_desc(32'h3000, 32'h4000, 15'd0);
        repeat (5) @(negedge ACLK);
        drain("zero");
        chk("zero_triggers", 64'(trig_cnt - t0), 64'(ZERO_TRIGS));
        chk("zero_done", 64'(done_cnt_o), 64'(1));

        // Random traffic with random engine latencies.
        eng_fixed = 0;
        for (int c = 0; c < 600; c++) begin
            push_i      = ($urandom_range(0, 2) == 0);
            push_src_i  = $urandom;
            push_dst_i  = $urandom;
            push_size_i = ($urandom_range(0, 5) == 0) ? '0 : SW'($urandom);
            flush_i     = ($urandom_range(0, 39) == 0);
            clr_ovf_i   = ($urandom_range(0, 14) == 0);
            @(negedge ACLK);
        end
        push_i    = 1'b0;
        flush_i   = 1'b0;
        clr_ovf_i = 1'b0;
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_up_desc_queue.md
AXI_UP_DESC_QUEUE -- requirements
Module: axi_up_desc_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of descriptor slots (power of two, 2..16).
REQ-002 SHALL have parameter REG_SIZE_WIDTH, default 15, transfer size width in bytes.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have port ACLK, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports push_i (input, 1), push_src_i (input, AXI_ADDR_WIDTH), push_dst_i (input, AXI_ADDR_WIDTH) and push_size_i (input, REG_SIZE_WIDTH), carrying a descriptor written by software.
REQ-007 SHALL have port flush_i, input, 1, discards queued (not in-flight) descriptors.
REQ-008 SHALL have port clr_ovf_i, input, 1, clears the overflow flag.
REQ-009 SHALL have ports src_addr_o, dst_addr_o (output, AXI_ADDR_WIDTH) and size_o (output, REG_SIZE_WIDTH), carrying the descriptor to the copy engine.
REQ-010 SHALL have port cmd_trigger_pulse_o, output, 1, one-cycle start to the copy engine.
REQ-011 SHALL have port status_busy_i, input, 1, copy engine busy.
REQ-012 SHALL have ports count_o (output, $clog2(DEPTH+1), queued entries), full_o (output, 1), empty_o (output, 1), overflow_o (output, 1, sticky) and done_cnt_o (output, 8, completed descriptors).

Function
REQ-013 SHALL implement a circular FIFO of DEPTH entries with wrapping read and write pointers.
REQ-014 SHALL accept a push when push_i=1 and full_o=0; the entry is visible in count_o the next cycle.
REQ-015 SHALL, when push_i=1 and full_o=1, drop the descriptor and set overflow_o the next cycle.
REQ-016 SHALL hold overflow_o until clr_ovf_i; if a set and a clear occur in the same cycle, the set wins.
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-018 SHALL go IDLE->ISSUE when empty_o=0 and status_busy_i=0, loading the head entry into the registered src/dst/size outputs.
REQ-019 SHALL, in ISSUE, assert cmd_trigger_pulse_o for exactly one cycle and then go to WAIT_BUSY; the trigger therefore rises one cycle after leaving IDLE.
REQ-020 SHALL go WAIT_BUSY->WAIT_DONE on status_busy_i=1.
REQ-021 SHALL go WAIT_DONE->IDLE on status_busy_i=0, popping the head entry and incrementing done_cnt_o; done_cnt_o wraps 255->0.
REQ-022 SHALL hold src/dst/size outputs stable from ISSUE until return to IDLE.
REQ-023 SHALL keep the in-flight entry counted in count_o until it is popped.
REQ-024 SHALL, on a pop and a push in the same cycle, leave count_o unchanged; a push when full is still rejected (no bypass).
REQ-025 SHALL, on flush_i, remove all entries except the in-flight one (if any) the next cycle; a push in the same cycle as a flush is discarded without setting overflow.
REQ-026 SHALL compute full_o as count_o==DEPTH and empty_o as count_o==0, both combinationally from registered state.

Reset
REQ-027 SHALL, on ARESET at any time (including mid-transfer), return the FSM to IDLE and clear both pointers, count_o, overflow_o, done_cnt_o, cmd_trigger_pulse_o and src/dst/size outputs to 0; empty_o=1 and full_o=0.

Configuration
REQ-028 SHALL support macro AXI_UP_ZERO_SIZE_DROP_EN.
REQ-029 SHALL, when AXI_UP_ZERO_SIZE_DROP_EN is defined, pop a head entry with size 0 from IDLE in one cycle without trigger; done_cnt_o is incremented.
REQ-030 SHALL, without AXI_UP_ZERO_SIZE_DROP_EN, issue a size-0 entry like any other.

Structure
REQ-031 SHALL place the FSM state enum and descriptor struct type (src, dst, size) in package axi_up_pkg.
REQ-032 SHALL implement storage in sub-module axi_up_desc_fifo, with the FSM in the top module.

Verification
REQ-033 SHALL cover single descriptor: push src=0x1000, dst=0x2000, size=64 -> trigger one cycle with those outputs; busy 1->0 gives done_cnt_o=1 and empty_o=1.
REQ-034 SHALL cover fill and overflow: with DEPTH=4 and the engine held busy, push 5 -> full_o=1, overflow_o=1, count_o=4; clr_ovf_i clears it.
REQ-035 SHALL cover back-to-back: push 3 and the engine completes each in 10 cycles -> 3 triggers in order, done_cnt_o=3, no trigger while busy.
REQ-036 SHALL cover flush: 3 queued, flush during WAIT_DONE -> count_o=1 next cycle; after done, empty_o=1 and done_cnt_o=1.
REQ-037 SHALL cover reset mid-transfer: ARESET in WAIT_DONE -> all outputs zero and no trigger after release until a new push.
REQ-038 SHALL cover zero size: push size=0 -> with the macro, no trigger and done_cnt_o=1; without it, one trigger.
